// File: rtl/digit_serial_adder.sv
// Digit-serial two's-complement adder/subtractor.
//
// One D-bit digit of the captured operands is added per clock, LSB digit first,
// so an N-bit operation takes N/D RUN cycles. The result, carry-out and
// overflow flag are published together on the cycle that finishes the last
// digit. They then hold until the next operation completes.
//
// Parameters:
//   N     - operand and sum width in bits
//   D     - digit width in bits per cycle (N must be a positive multiple of D)
//
// Ports:
//   clk   - clock, all state changes on the rising edge
//   rstn  - synchronous active-low reset
//   start - begin an operation (accepted only while idle)
//   sub   - 0 = a + b + cin, 1 = a - b
//   a, b  - operands, sampled only on the start-accept edge
//   cin   - carry-in, add mode only
//   sum   - registered result
//   cout  - registered carry out of the MSB (in subtract mode, 1 = no borrow)
//   ovf   - registered two's-complement overflow flag
//   busy  - high while digits are being processed
//   done  - one-cycle pulse when sum/cout/ovf have been updated
module digit_serial_adder #(
    parameter int unsigned N = 8,
    parameter int unsigned D = 2
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         start,
    input  logic         sub,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         cin,
    output logic [N-1:0] sum,
    output logic         cout,
    output logic         ovf,
    output logic         busy,
    output logic         done
);

    localparam int unsigned NumDigits = N / D;
    localparam int unsigned CntW      = (NumDigits > 1) ? $clog2(NumDigits) : 1;
    localparam logic [CntW-1:0] LastDigit = CntW'(NumDigits - 1);

    typedef enum logic {
        StIdle,
        StRun
    } state_e;

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [N-1:0]    a_q, a_d;
    logic [N-1:0]    b_q, b_d;
    logic            carry_q, carry_d;
    logic [N-1:0]    res_q, res_d;
    logic [N-1:0]    sum_q, sum_d;
    logic            cout_q, cout_d;
    logic            ovf_q, ovf_d;
    logic            done_q, done_d;

    // Digit datapath
    int unsigned     lsb;
    logic [D-1:0]    a_dig;
    logic [D-1:0]    b_dig;
    logic [D:0]      dig_sum;
    logic            c_msb_in;

    always_comb begin
        lsb     = 32'(cnt_q) * D;
        a_dig   = a_q[lsb +: D];
        b_dig   = b_q[lsb +: D];
        dig_sum = {1'b0, a_dig} + {1'b0, b_dig} + {{D{1'b0}}, carry_q};
        // The carry into the top bit of a digit is recovered from that bit's
        // sum; on the last digit this is the carry into the operand MSB.
        c_msb_in = dig_sum[D-1] ^ a_dig[D-1] ^ b_dig[D-1];
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        carry_d = carry_q;
        res_d   = res_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        done_d  = 1'b0;

        case (state_q)
            StIdle: begin
                if (start) begin
                    a_d     = a;
                    // Subtraction is a + ~b + 1.
                    b_d     = sub ? ~b : b;
                    carry_d = sub ? 1'b1 : cin;
                    cnt_d   = '0;
                    state_d = StRun;
                end
            end
            StRun: begin
                res_d[lsb +: D] = dig_sum[D-1:0];
                carry_d         = dig_sum[D];
                if (cnt_q == LastDigit) begin
                    sum_d   = res_d;
                    cout_d  = dig_sum[D];
                    ovf_d   = c_msb_in ^ dig_sum[D];
                    done_d  = 1'b1;
                    cnt_d   = '0;
                    state_d = StIdle;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            carry_q <= 1'b0;
            res_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            carry_q <= carry_d;
            res_q   <= res_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
            done_q  <= done_d;
        end
    end

    assign sum  = sum_q;
    assign cout = cout_q;
    assign ovf  = ovf_q;
    assign busy = (state_q == StRun);
    assign done = done_q;

endmodule

// File: tb/tb_digit_serial_adder.sv
// Directed and reference-model checks of digit_serial_adder in three
// configurations: (N=8, D=2), (N=4, D=4) and (N=16, D=4).
module tb_digit_serial_adder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rstn;
    logic        st [3];
    logic        sb [3];
    logic        ci [3];
    logic        co [3];
    logic        ov [3];
    logic        bz [3];
    logic        dn [3];
    logic [7:0]  a8, b8, sum8;
    logic [3:0]  a4, b4, sum4;
    logic [15:0] a16, b16, sum16;

    int errors = 0;
    int checks = 0;

    digit_serial_adder #(.N(8), .D(2)) u_dut8 (
        .clk(clk), .rstn(rstn), .start(st[0]), .sub(sb[0]), .a(a8), .b(b8), .cin(ci[0]),
        .sum(sum8), .cout(co[0]), .ovf(ov[0]), .busy(bz[0]), .done(dn[0])
    );

    digit_serial_adder #(.N(4), .D(4)) u_dut4 (
        .clk(clk), .rstn(rstn), .start(st[1]), .sub(sb[1]), .a(a4), .b(b4), .cin(ci[1]),
        .sum(sum4), .cout(co[1]), .ovf(ov[1]), .busy(bz[1]), .done(dn[1])
    );

    digit_serial_adder #(.N(16), .D(4)) u_dut16 (
        .clk(clk), .rstn(rstn), .start(st[2]), .sub(sb[2]), .a(a16), .b(b16), .cin(ci[2]),
        .sum(sum16), .cout(co[2]), .ovf(ov[2]), .busy(bz[2]), .done(dn[2])
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic drive(input int sel, input logic [15:0] a, input logic [15:0] b,
                         input logic c, input logic s, input logic go);
        case (sel)
            0:       begin a8 = a[7:0]; b8 = b[7:0]; end
            1:       begin a4 = a[3:0]; b4 = b[3:0]; end
            default: begin a16 = a; b16 = b; end
        endcase
        ci[sel] = c;
        sb[sel] = s;
        st[sel] = go;
    endtask

    // {ovf, cout, sum zero-extended to 16 bits}
    function automatic logic [17:0] observed(input int sel);
        case (sel)
            0:       return {ov[0], co[0], 8'd0, sum8};
            1:       return {ov[1], co[1], 12'd0, sum4};
            default: return {ov[2], co[2], sum16};
        endcase
    endfunction

    function automatic logic [17:0] ref_model(input int n, input logic [15:0] a,
                                              input logic [15:0] b, input logic c,
                                              input logic s);
        logic [16:0] mask, bb, t;
        logic [15:0] sm;
        logic        co_r, ov_r;
        mask = (17'd1 << n) - 17'd1;
        bb   = {1'b0, (s ? ~b : b)} & mask;
        t    = ({1'b0, a} & mask) + bb + {16'd0, (s ? 1'b1 : c)};
        co_r = t[n];
        sm   = t[15:0] & mask[15:0];
        ov_r = (a[n-1] == bb[n-1]) && (sm[n-1] != a[n-1]);
        return {ov_r, co_r, sm};
    endfunction

    // Start an operation, scramble the operand inputs afterwards, and wait for done.
    // lat counts rising edges after the accept edge; busy_cnt counts busy cycles.
    task automatic run_op(input int sel, input logic [15:0] a, input logic [15:0] b,
                          input logic c, input logic s, output int lat, output int busy_cnt,
                          output logic [17:0] res);
        @(negedge clk);
        drive(sel, a, b, c, s, 1'b1);
        @(negedge clk);
        drive(sel, ~a, ~b, ~c, ~s, 1'b0);
        lat      = 0;
        busy_cnt = bz[sel] ? 1 : 0;
        while (!dn[sel] && lat < 64) begin
            @(negedge clk);
            lat++;
            if (bz[sel]) busy_cnt++;
        end
        res = observed(sel);
    endtask

    task automatic op_check(input int sel, input string tag, input logic [15:0] a,
                            input logic [15:0] b, input logic c, input logic s,
                            input int exp_lat, input logic [17:0] exp);
        int          lat, busy_cnt;
        logic [17:0] res;
        run_op(sel, a, b, c, s, lat, busy_cnt, res);
        check($sformatf("%s_latency", tag), lat, exp_lat);
        check($sformatf("%s_busy_cycles", tag), busy_cnt, exp_lat);
        check($sformatf("%s_result", tag), {14'd0, res}, {14'd0, exp});
        @(negedge clk);
        check($sformatf("%s_done_one_cycle", tag), {31'd0, dn[sel]}, 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
        $fatal(1);
    end

    initial begin
        int          n, lat, res_w;
        logic [15:0] ra, rb;
        logic        rc, rs;
        int          nbits [3];
        int          lats  [3];
        nbits = '{8, 4, 16};
        lats  = '{4, 1, 4};

        rstn = 1'b0;
        for (int i = 0; i < 3; i++) drive(i, 16'd0, 16'd0, 1'b0, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        check("reset_result", {14'd0, observed(0)}, 32'd0);
        check("reset_busy", {31'd0, bz[0]}, 32'd0);
        check("reset_done", {31'd0, dn[0]}, 32'd0);
        rstn = 1'b1;

        // Directed 8-bit vectors: expected {ovf, cout, sum}
        op_check(0, "add_basic",  16'h01, 16'h00, 1'b1, 1'b0, 4, {1'b0, 1'b0, 16'h0002});
        op_check(0, "add_wrap",   16'hFF, 16'h00, 1'b1, 1'b0, 4, {1'b0, 1'b1, 16'h0000});
        op_check(0, "add_ovf",    16'h7F, 16'h01, 1'b0, 1'b0, 4, {1'b1, 1'b0, 16'h0080});
        op_check(0, "sub_basic",  16'h10, 16'h01, 1'b1, 1'b1, 4, {1'b0, 1'b1, 16'h000F});
        op_check(0, "sub_borrow", 16'h00, 16'h01, 1'b0, 1'b1, 4, {1'b0, 1'b0, 16'h00FF});

        // Start during RUN is ignored; start in the done cycle is accepted.
        @(negedge clk);
        drive(0, 16'h05, 16'h03, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        drive(0, 16'h00, 16'h00, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        drive(0, 16'hF0, 16'h03, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        drive(0, 16'h00, 16'h00, 1'b0, 1'b0, 1'b0);
        lat = 2;
        while (!dn[0] && lat < 64) begin
            @(negedge clk);
            lat++;
        end
        check("ignore_start_latency", lat, 4);
        check("ignore_start_sum", {24'd0, sum8}, 32'h08);
        drive(0, 16'h11, 16'h22, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        drive(0, 16'h00, 16'h00, 1'b0, 1'b0, 1'b0);
        n = 1;
        while (!dn[0] && n < 64) begin
            @(negedge clk);
            n++;
        end
        check("back_to_back_spacing", n, 5);
        check("back_to_back_sum", {24'd0, sum8}, 32'h33);

        // Reset in the cycle that would process digit 2.
        @(negedge clk);
        drive(0, 16'h21, 16'h12, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        drive(0, 16'h00, 16'h00, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        @(negedge clk);
        rstn = 1'b0;
        @(negedge clk);
        check("abort_result", {14'd0, observed(0)}, 32'd0);
        check("abort_busy", {31'd0, bz[0]}, 32'd0);
        check("abort_done", {31'd0, dn[0]}, 32'd0);
        rstn = 1'b1;
        n = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (dn[0]) n++;
        end
        check("abort_no_done", n, 0);
        op_check(0, "after_abort", 16'h21, 16'h12, 1'b0, 1'b0, 4, {1'b0, 1'b0, 16'h0033});

        // Reference-model sweep for each configuration
        for (int sel = 0; sel < 3; sel++) begin
            for (int i = 0; i < 10; i++) begin
                ra = 16'($urandom);
                rb = 16'($urandom);
                rc = 1'($urandom);
                rs = 1'($urandom);
                res_w = nbits[sel];
                op_check(sel, $sformatf("rand_n%0d_%0d", res_w, i), ra, rb, rc, rs, lats[sel],
                         ref_model(res_w, ra, rb, rc, rs));
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
